// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for the pattern detector.
// One-word holding register in front of a shifter; words chain with no gap.
module serial_word_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] shreg;
    logic             hold_full;
    logic [CW-1:0]    cnt;

    logic accept;
    logic last;
    logic load;
    logic hold_nxt;
    logic shift_nxt;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign accept    = in_valid && in_ready;
    assign last      = (state == SHIFT) && (cnt == LAST);
    // Held word moves to the shifter when idle or as the last bit ends.
    assign load      = hold_full && ((state == IDLE) || last);
    assign hold_nxt  = accept || (hold_full && !load);
    assign shift_nxt = load || ((state == SHIFT) && !last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_q    <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            hold_full <= hold_nxt;
            in_ready  <= !hold_nxt;
            busy      <= hold_nxt || shift_nxt;
            if (accept) begin
                hold_q <= in_data;
            end
            if (load) begin
                state     <= SHIFT;
                shreg     <= advance(hold_q);
                cnt       <= '0;
                x         <= first_bit(hold_q);
                x_valid   <= 1'b1;
                word_done <= 1'b0;
            end else if (last) begin
                state     <= IDLE;
                x         <= IDLE_BIT;
                x_valid   <= 1'b0;
                word_done <= 1'b0;
            end else if (state == SHIFT) begin
                cnt       <= cnt + CW'(1);
                shreg     <= advance(shreg);
                x         <= first_bit(shreg);
                word_done <= (cnt == PRE_LAST);
            end
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: MSB-first and LSB-first instances
// against a bit-queue reference model and a word scoreboard.
module tb_serial_word_feeder;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       x_o[2];
    logic       xv_o[2];
    logic       wd_o[2];
    logic       rdy_o[2];
    logic       busy_o[2];

    int checks;
    int failures;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_o[0]), .x(x_o[0]), .x_valid(xv_o[0]),
        .word_done(wd_o[0]), .busy(busy_o[0])
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_o[1]), .x(x_o[1]), .x_valid(xv_o[1]),
        .word_done(wd_o[1]), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits still to appear on x, plus the held word.
    bit         bq[2][$];
    logic [7:0] hold_m[2];
    bit         hold_v[2];
    logic [7:0] sent_q[$];
    bit         last_acc;
    int         cyc_n;

    logic [7:0]  rx;
    logic [31:0] cap0;
    logic [31:0] cap1;
    int          run;
    int          maxrun;
    int          ndone;
    int          nvalid;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int m, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            bq[m].push_back(m == 0 ? w[7-i] : w[i]);
        end
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d);
        bit acc;
        acc = v && !hold_v[0];
        for (int m = 0; m < 2; m++) begin
            if (bq[m].size() > 0) begin
                void'(bq[m].pop_front());
            end
            if (bq[m].size() == 0 && hold_v[m]) begin
                push_word(m, hold_m[m]);
                hold_v[m] = 1'b0;
            end
            if (acc) begin
                hold_m[m] = d;
                hold_v[m] = 1'b1;
            end
        end
        if (acc) sent_q.push_back(d);
        last_acc = acc;
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            bq[m].delete();
            hold_v[m] = 1'b0;
        end
        sent_q.delete();
        last_acc = 1'b0;
        rx = '0;
    endtask

    task automatic clear_caps();
        cap0 = '0; cap1 = '0;
        run = 0; maxrun = 0; ndone = 0; nvalid = 0;
    endtask

    task automatic check_outputs();
        logic ex;
        for (int m = 0; m < 2; m++) begin
            ex = (bq[m].size() > 0) ? bq[m][0] : 1'b1;
            chk($sformatf("x[%0d]", m), x_o[m], ex);
            chk($sformatf("x_valid[%0d]", m), xv_o[m], bq[m].size() > 0);
            chk($sformatf("word_done[%0d]", m), wd_o[m], bq[m].size() == 1);
            chk($sformatf("in_ready[%0d]", m), rdy_o[m], !hold_v[m]);
            chk($sformatf("busy[%0d]", m), busy_o[m],
                (bq[m].size() > 0) || hold_v[m]);
        end
        if (xv_o[0]) begin
            rx = {rx[6:0], x_o[0]};
            cap0 = {cap0[30:0], x_o[0]};
            nvalid++;
            run++;
            if (run > maxrun) maxrun = run;
            if (wd_o[0]) begin
                ndone++;
                if (sent_q.size() == 0) begin
                    chk("word_extra", sent_q.size(), 1);
                end else begin
                    chk("word", rx, sent_q.pop_front());
                end
            end
        end else begin
            run = 0;
        end
        if (xv_o[1]) cap1 = {cap1[30:0], x_o[1]};
    endtask

    task automatic cyc(input bit v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge(v, d);
        cyc_n++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom));
    endtask

    task automatic send_words(input logic [7:0] words[$], output int acc_t[$]);
        int budget;
        budget = 20 * (words.size() + 1);
        acc_t.delete();
        while (words.size() > 0 && budget > 0) begin
            cyc(1'b1, words[0]);
            if (last_acc) begin
                void'(words.pop_front());
                acc_t.push_back(cyc_n);
            end
            budget--;
        end
        if (words.size() > 0) chk("send_timeout", words.size(), 0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_x", x_o[m], 1'b1);
            chk("rst_x_valid", xv_o[m], 1'b0);
            chk("rst_word_done", wd_o[m], 1'b0);
            chk("rst_in_ready", rdy_o[m], 1'b1);
            chk("rst_busy", busy_o[m], 1'b0);
        end
        model_clear();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] w[$];
        int         at[$];
        int         bound;
        bit         cv;
        logic [7:0] cd;

        checks = 0; failures = 0; cyc_n = 0;
        in_valid = 1'b0; in_data = '0;
        model_clear();
        clear_caps();
        reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("init_x", x_o[m], 1'b1);
            chk("init_in_ready", rdy_o[m], 1'b1);
            chk("init_busy", busy_o[m], 1'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        idle(50);

        clear_caps();
        cyc(1'b1, 8'h24);
        chk("acc_24", last_acc, 1'b1);
        idle(12);
        chk("w24_bits", cap0[7:0], 8'h24);
        chk("w24_len", nvalid, 8);
        chk("w24_done", ndone, 1);
        chk("w24_idle_x", x_o[0], 1'b1);
        chk("w24_idle_busy", busy_o[0], 1'b0);

        clear_caps();
        w = '{8'hA5, 8'h3C};
        send_words(w, at);
        idle(20);
        chk("pair_bits", cap0[15:0], 16'hA53C);
        chk("pair_run", maxrun, 16);
        chk("pair_done", ndone, 2);

        clear_caps();
        w.delete();
        for (int i = 0; i < 10; i++) w.push_back(8'($urandom));
        send_words(w, at);
        idle(30);
        chk("stream_accepts", at.size(), 10);
        for (int k = 2; k < at.size(); k++) begin
            chk("stream_spacing", at[k] - at[k-1], 8);
        end
        chk("stream_run", maxrun, 80);
        chk("stream_done", ndone, 10);

        w = '{8'hFF, 8'h00};
        send_words(w, at);
        bound = 20;
        while (bq[0].size() != 6 && bound > 0) begin
            cyc(1'b0, 8'h00);
            bound--;
        end
        chk("mid_word_reached", bq[0].size(), 6);
        chk("mid_word_busy", busy_o[0], 1'b1);
        chk("mid_word_held", rdy_o[0], 1'b0);
        do_reset();
        clear_caps();
        idle(20);
        chk("post_rst_bits", nvalid, 0);

        clear_caps();
        w = '{8'h01, 8'h04};
        send_words(w, at);
        idle(20);
        chk("lsb_bits", cap1[15:0], 16'h8020);

        cv = 1'b0; cd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!cv || last_acc) begin
                cv = 1'($urandom_range(0, 3) != 0);
                cd = 8'($urandom);
            end
            cyc(cv, cd);
        end
        idle(30);
        chk("rand_drained", sent_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
